// File: rtl/instr_encoder.sv
// Program loader: encodes op/argument commands into 11-bit instruction words,
// buffers them in a small FIFO and writes them sequentially into instruction memory.
module instr_encoder #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned IMEM_AW = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [7:0]         cmd_arg,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [10:0]        imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [10:0]        fifo_q [DEPTH];
   logic [10:0]        fifo_d [DEPTH];
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   // Extra MSB marks that the last address has already been written.
   logic [IMEM_AW:0]   wptr_q, wptr_d;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic [10:0]        imem_wdata_q, imem_wdata_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               legal;
   logic [10:0]        enc_word;
   logic               fifo_full, fifo_empty;
   logic               accept, push, pop;
   logic [10:0]        head;
   logic               head_is_halt;
   logic               addr_ovf;

   // Immediate/taps overlap the opcode field, so the low arg bits must match it.
   always_comb begin
      legal    = 1'b1;
      enc_word = {8'b0, cmd_op};
      unique case (cmd_op)
         3'b010, 3'b011: begin
            enc_word = {3'b0, cmd_arg[7:3], cmd_op};
            legal    = (cmd_arg[2:0] == cmd_op);
         end
         3'b100: begin
            enc_word = {4'b0, cmd_arg[6:3], cmd_op};
            legal    = (cmd_arg[2:0] == 3'b100) && !cmd_arg[7];
         end
         default: ;
      endcase
   end

   always_comb begin
      fifo_full    = (count_q == CntW'(DEPTH));
      fifo_empty   = (count_q == '0);
      accept       = cmd_valid && cmd_ready;
      push         = accept && legal;
      pop          = !start && !fifo_empty && ((state_q == StLoad) || (state_q == StDrain));
      head         = fifo_q[rd_ptr_q];
      head_is_halt = (head[2:0] == 3'b111);
      addr_ovf     = wptr_q[IMEM_AW];
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = StLoad;
      end else begin
         unique case (state_q)
            StIdle:  ;
            StLoad:  if (accept && (cmd_op == 3'b111)) state_d = StDrain;
            StDrain: if (pop && head_is_halt) state_d = StDone;
            StDone:  ;
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs
   always_comb begin
      cmd_ready  = (state_q == StLoad) && !fifo_full && !start;
      busy       = (state_q == StLoad) || (state_q == StDrain);
      imem_we    = imem_we_q;
      imem_addr  = imem_addr_q;
      imem_wdata = imem_wdata_q;
      done       = done_q;
      err        = err_q;
   end

   // FIFO, write pointer and registered memory port
   always_comb begin
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      wptr_d       = wptr_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      err_d        = err_q;
      done_d       = (state_q == StDone) && !start;
      if (start) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         wptr_d   = '0;
         err_d    = 1'b0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = enc_word;
            wr_ptr_d         = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (addr_ovf) begin
               err_d = 1'b1;
            end else begin
               imem_we_d    = 1'b1;
               imem_addr_d  = wptr_q[IMEM_AW-1:0];
               imem_wdata_d = head;
               wptr_d       = wptr_q + 1'b1;
            end
         end
         if (accept && !legal) err_d = 1'b1;
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         wptr_q       <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         wptr_q       <= wptr_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (8-bit and 2-bit address) driven in lockstep and
// compared each cycle against a queue-based reference model, plus directed scenario checks.
module tb_instr_encoder;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, cmd_valid;
   logic [2:0] cmd_op;
   logic [7:0] cmd_arg;

   logic        rdy8, we8, busy8, done8, err8;
   logic [7:0]  addr8;
   logic [10:0] wd8;
   logic        rdy2, we2, busy2, done2, err2;
   logic [1:0]  addr2;
   logic [10:0] wd2;

   instr_encoder #(.DEPTH(DEPTH), .IMEM_AW(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy8),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .imem_we(we8), .imem_addr(addr8),
      .imem_wdata(wd8), .busy(busy8), .done(done8), .err(err8)
   );

   instr_encoder #(.DEPTH(DEPTH), .IMEM_AW(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .imem_we(we2), .imem_addr(addr2),
      .imem_wdata(wd2), .busy(busy2), .done(done2), .err(err2)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 idle, 1 load, 2 drain, 3 done. Index 0 = 256 words, 1 = 4 words.
   int          m_mode;
   logic [10:0] m_q[$];
   int          m_wptr[2];
   logic        m_we[2];
   int          m_addr[2];
   logic [10:0] m_wdata[2];
   logic        m_err[2];
   logic        m_done;

   logic [10:0] mem8[256];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int mem_words(input int k);
      return (k == 0) ? 256 : 4;
   endfunction

   task automatic encode(input logic [2:0] op, input logic [7:0] arg, output bit ok,
                         output logic [10:0] w);
      int a = int'(arg);
      int o = int'(op);
      ok = 1'b1;
      w  = 11'(o);
      if (o == 2 || o == 3) begin
         ok = ((a % 8) == o);
         w  = 11'((a / 8) * 8 + o);
      end else if (o == 4) begin
         ok = ((a % 8) == 4) && (a < 128);
         w  = 11'(((a / 8) % 16) * 8 + 4);
      end
   endtask

   task automatic model_update(input logic rst, input logic st, input logic v,
                               input logic [2:0] op, input logic [7:0] a, input logic rdy);
      logic [10:0] w;
      bit          ok;
      bit          next_done;
      if (rst) begin
         m_mode = 0;
         m_q.delete();
         m_done = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_wptr[k] = 0; m_we[k] = 1'b0; m_addr[k] = 0; m_wdata[k] = '0; m_err[k] = 1'b0;
         end
      end else if (st) begin
         m_mode = 1;
         m_q.delete();
         m_done = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_wptr[k] = 0; m_we[k] = 1'b0; m_err[k] = 1'b0;
         end
      end else begin
         next_done = (m_mode == 3);
         if (m_q.size() > 0 && (m_mode == 1 || m_mode == 2)) begin
            w = m_q.pop_front();
            for (int k = 0; k < 2; k++) begin
               if (m_wptr[k] < mem_words(k)) begin
                  m_we[k] = 1'b1; m_addr[k] = m_wptr[k]; m_wdata[k] = w; m_wptr[k]++;
               end else begin
                  m_we[k] = 1'b0; m_err[k] = 1'b1;
               end
            end
            if (m_mode == 2 && w == 11'h007) m_mode = 3;
         end else begin
            for (int k = 0; k < 2; k++) m_we[k] = 1'b0;
         end
         if (v && rdy) begin
            encode(op, a, ok, w);
            if (ok) m_q.push_back(w);
            else for (int k = 0; k < 2; k++) m_err[k] = 1'b1;
            if (op == 3'b111) m_mode = 2;
         end
         m_done = next_done;
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic v, input logic [2:0] op,
                       input logic [7:0] a);
      logic erdy;
      logic ebusy;
      @(negedge clk);
      reset = rst; start = st; cmd_valid = v; cmd_op = op; cmd_arg = a;
      #1;
      erdy = (m_mode == 1) && (m_q.size() < DEPTH) && !st;
      check_eq("ready8", 32'(rdy8), 32'(erdy));
      check_eq("ready2", 32'(rdy2), 32'(erdy));
      model_update(rst, st, v, op, a, erdy);
      @(posedge clk);
      #1;
      ebusy = (m_mode == 1) || (m_mode == 2);
      check_eq("we8", 32'(we8), 32'(m_we[0]));
      check_eq("addr8", 32'(addr8), 32'(m_addr[0]));
      check_eq("wdata8", 32'(wd8), 32'(m_wdata[0]));
      check_eq("err8", 32'(err8), 32'(m_err[0]));
      check_eq("done8", 32'(done8), 32'(m_done));
      check_eq("busy8", 32'(busy8), 32'(ebusy));
      check_eq("we2", 32'(we2), 32'(m_we[1]));
      check_eq("addr2", 32'(addr2), 32'(m_addr[1]));
      check_eq("wdata2", 32'(wd2), 32'(m_wdata[1]));
      check_eq("err2", 32'(err2), 32'(m_err[1]));
      check_eq("done2", 32'(done2), 32'(m_done));
      check_eq("busy2", 32'(busy2), 32'(ebusy));
      if (we8) mem8[addr8] = wd8;
   endtask

   task automatic cmd(input logic [2:0] op, input logic [7:0] a);
      step(1'b0, 1'b0, 1'b1, op, a);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
   endtask

   task automatic go();
      step(1'b0, 1'b1, 1'b0, 3'b000, 8'h00);
   endtask

   initial begin
      logic [2:0] op;
      logic [7:0] a;
      int         r;

      reset = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
      repeat (2) @(posedge clk);
      model_update(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, 3'b000, 8'h00);
      check_eq("rst_ready", 32'(rdy8), 32'd0);
      check_eq("rst_we", 32'(we8), 32'd0);
      check_eq("rst_wdata", 32'(wd8), 32'd0);
      idle(2);

      // Basic stream: init_addr 0x2A, ld, run, halt.
      go();
      cmd(3'b010, 8'h2A); cmd(3'b001, 8'h00); cmd(3'b110, 8'h00); cmd(3'b111, 8'h00);
      idle(3);
      check_eq("s1_mem0", 32'(mem8[0]), 32'h02A);
      check_eq("s1_mem1", 32'(mem8[1]), 32'h001);
      check_eq("s1_mem2", 32'(mem8[2]), 32'h006);
      check_eq("s1_mem3", 32'(mem8[3]), 32'h007);
      check_eq("s1_done", 32'(done8), 32'd1);
      check_eq("s1_err", 32'(err8), 32'd0);

      // Config legality.
      go();
      cmd(3'b100, 8'h5C); cmd(3'b100, 8'hDC); idle(1);
      check_eq("s2_err", 32'(err8), 32'd1);
      check_eq("s2_mem0", 32'(mem8[0]), 32'h05C);
      cmd(3'b111, 8'h00); idle(3);
      check_eq("s2_halt_at1", 32'(mem8[1]), 32'h007);

      // Back-to-back burst of six.
      go();
      cmd(3'b000, 8'h11); cmd(3'b001, 8'h22); cmd(3'b101, 8'h33);
      cmd(3'b110, 8'h44); cmd(3'b100, 8'h0C); cmd(3'b111, 8'h55);
      idle(3);
      check_eq("s3_mem0", 32'(mem8[0]), 32'h000);
      check_eq("s3_mem1", 32'(mem8[1]), 32'h001);
      check_eq("s3_mem2", 32'(mem8[2]), 32'h005);
      check_eq("s3_mem3", 32'(mem8[3]), 32'h006);
      check_eq("s3_mem4", 32'(mem8[4]), 32'h00C);
      check_eq("s3_mem5", 32'(mem8[5]), 32'h007);

      // Address overflow on the 4-word instance.
      go();
      for (int i = 0; i < 5; i++) cmd(3'b000, 8'h00);
      cmd(3'b111, 8'h00);
      idle(3);
      check_eq("s4_err2", 32'(err2), 32'd1);
      check_eq("s4_done2", 32'(done2), 32'd1);
      check_eq("s4_addr2", 32'(addr2), 32'd3);
      check_eq("s4_err8", 32'(err8), 32'd0);

      // Start while draining with the halt still queued.
      go();
      cmd(3'b011, 8'h01); cmd(3'b000, 8'h00); cmd(3'b111, 8'h00);
      go();
      cmd(3'b001, 8'h00); idle(1);
      check_eq("s5_we", 32'(we8), 32'd1);
      check_eq("s5_addr", 32'(addr8), 32'd0);
      check_eq("s5_data", 32'(wd8), 32'h001);
      check_eq("s5_done", 32'(done8), 32'd0);
      check_eq("s5_err", 32'(err8), 32'd0);

      // Reset in the middle of a load.
      cmd(3'b000, 8'h00); cmd(3'b001, 8'h00);
      step(1'b1, 1'b0, 1'b1, 3'b000, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cmd(3'b001, 8'h00);
         check_eq("s6_ready", 32'(rdy8), 32'd0);
      end
      check_eq("s6_busy", 32'(busy8), 32'd0);

      // Randomized programs.
      for (int p = 0; p < 40; p++) begin
         go();
         for (int c = 0; c < 40 && m_mode != 3 && m_mode != 0; c++) begin
            r  = int'($urandom_range(0, 99));
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b000;
            if ($urandom_range(0, 1) == 1) begin
               if (op == 3'b010 || op == 3'b011) a[2:0] = op;
               if (op == 3'b100) begin a[2:0] = 3'b100; a[7] = 1'b0; end
            end
            if (r < 2) step(1'b1, 1'b0, 1'b1, op, a);
            else if (r < 4) step(1'b0, 1'b1, 1'b1, op, a);
            else step(1'b0, 1'b0, (r < 70), op, a);
         end
         idle(3);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
